pdm_fft_frontend: RTL and testbench



---
 rtl/pdm_fft_frontend.sv | 157 +++++++++++++++
 tb/tb_pdm_fft_frontend.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_fft_frontend.sv
// PDM microphone front end: mic clock generation, ones-count decimation and
// frame packing into a small AXI-stream FIFO feeding the FFT core.
module pdm_fft_frontend #(
  parameter int unsigned CLK_DIV    = 32,
  parameter int unsigned DECIM      = 256,
  parameter int unsigned SAMPLE_W   = 8,
  parameter int unsigned FRAME_LEN  = 1024,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                mic_data_in,
  input  logic                enable_in,
  output logic                mic_clk_out,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_valid_out,
  output logic [31:0]         m_axis_tdata,
  output logic                m_axis_tvalid,
  output logic                m_axis_tlast,
  input  logic                m_axis_tready,
  output logic                overflow_out,
  output logic [15:0]         frame_count_out
);

  localparam int unsigned DivW = $clog2(CLK_DIV);
  localparam int unsigned DecW = $clog2(DECIM);
  localparam int unsigned FrmW = $clog2(FRAME_LEN);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  logic [DivW-1:0]     div_q, div_d;
  logic                mic_clk_q, mic_clk_d;
  logic [DecW-1:0]     bit_q, bit_d;
  logic [DecW:0]       tally_q, tally_d, tally_sum;
  logic [SAMPLE_W-1:0] sample_q, sample_d, sample_sel;
  logic                sample_valid_q, sample_valid_d;
  logic [FrmW-1:0]     idx_q, idx_d;
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]       count_q, count_d, occ_after_pop;
  logic                tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic [31:0]         tdata_q, tdata_d;
  logic                overflow_q, overflow_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic [32:0]         mem_q [FIFO_DEPTH];

  logic        pdm_stb, last_bit, in_frame, fifo_full, push, pop, push_last;
  logic [32:0] push_data;

  always_comb begin
    pdm_stb   = (div_q == DivW'(CLK_DIV - 1));
    div_d     = pdm_stb ? '0 : div_q + DivW'(1);
    mic_clk_d = (div_q < DivW'(CLK_DIV / 2));

    last_bit   = pdm_stb && (bit_q == DecW'(DECIM - 1));
    tally_sum  = tally_q + (DecW + 1)'(mic_data_in);
    // A full-scale count of DECIM saturates to all ones in the selected field.
    sample_sel = tally_sum[DecW] ? {SAMPLE_W{1'b1}} : tally_sum[DecW-1 -: SAMPLE_W];

    bit_d          = bit_q;
    tally_d        = tally_q;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;
    if (pdm_stb) begin
      bit_d = bit_q + DecW'(1);
      if (last_bit) begin
        tally_d        = '0;
        sample_d       = sample_sel ^ (SAMPLE_W'(1) << (SAMPLE_W - 1));
        sample_valid_d = 1'b1;
      end else begin
        tally_d = tally_sum;
      end
    end
  end

  always_comb begin
    in_frame  = (idx_q != '0) || enable_in;
    fifo_full = (count_q == (PtrW + 1)'(FIFO_DEPTH));
    push      = sample_valid_q && in_frame && !fifo_full;
    pop       = tvalid_q && m_axis_tready;
    push_last = (idx_q == FrmW'(FRAME_LEN - 1));
    push_data = {push_last, sample_q, {(32 - SAMPLE_W){1'b0}}};

    overflow_d = overflow_q | (sample_valid_q && in_frame && fifo_full);
    idx_d      = idx_q;
    if (push) idx_d = push_last ? '0 : idx_q + FrmW'(1);

    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (PtrW + 1)'(1);
      2'b01:   count_d = count_q - (PtrW + 1)'(1);
      default: count_d = count_q;
    endcase

    // Head register: the just-pushed word bypasses memory when nothing precedes it.
    occ_after_pop = count_q - (PtrW + 1)'(pop);
    tvalid_d      = (count_d != '0);
    if (occ_after_pop != '0) begin
      {tlast_d, tdata_d} = mem_q[rd_ptr_d];
    end else if (push) begin
      {tlast_d, tdata_d} = push_data;
    end else begin
      {tlast_d, tdata_d} = '0;
    end

    frame_cnt_d = (pop && tlast_q) ? frame_cnt_q + 16'd1 : frame_cnt_q;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      div_q          <= '0;
      mic_clk_q      <= 1'b0;
      bit_q          <= '0;
      tally_q        <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      idx_q          <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      tvalid_q       <= 1'b0;
      tlast_q        <= 1'b0;
      tdata_q        <= '0;
      overflow_q     <= 1'b0;
      frame_cnt_q    <= '0;
    end else begin
      div_q          <= div_d;
      mic_clk_q      <= mic_clk_d;
      bit_q          <= bit_d;
      tally_q        <= tally_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      idx_q          <= idx_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      tvalid_q       <= tvalid_d;
      tlast_q        <= tlast_d;
      tdata_q        <= tdata_d;
      overflow_q     <= overflow_d;
      frame_cnt_q    <= frame_cnt_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign mic_clk_out      = mic_clk_q;
  assign sample_out       = sample_q;
  assign sample_valid_out = sample_valid_q;
  assign m_axis_tdata     = tdata_q;
  assign m_axis_tvalid    = tvalid_q;
  assign m_axis_tlast     = tlast_q;
  assign overflow_out     = overflow_q;
  assign frame_count_out  = frame_cnt_q;

endmodule

// File: tb/tb_pdm_fft_frontend.sv
// Scoreboard bench: driver streams PDM bits and predicts samples/beats; a negedge
// monitor pops predictions when the DUT strobes a sample or transfers a beat.
module tb_pdm_fft_frontend;

  localparam int CLK_DIV   = 4;
  localparam int DECIM     = 16;
  localparam int SW        = 4;
  localparam int LG        = 4;
  localparam int FRAME_LEN = 4;
  localparam int DEPTH     = 4;
  localparam int SPER      = CLK_DIV * DECIM;

  logic          clk_in, rst_in, mic_data_in, enable_in, m_axis_tready;
  logic          mic_clk_out, sample_valid_out, m_axis_tvalid, m_axis_tlast, overflow_out;
  logic [SW-1:0] sample_out;
  logic [31:0]   m_axis_tdata;
  logic [15:0]   frame_count_out;

  pdm_fft_frontend #(
    .CLK_DIV(CLK_DIV), .DECIM(DECIM), .SAMPLE_W(SW), .FRAME_LEN(FRAME_LEN), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .mic_data_in(mic_data_in), .enable_in(enable_in),
    .mic_clk_out(mic_clk_out), .sample_out(sample_out), .sample_valid_out(sample_valid_out),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready), .overflow_out(overflow_out),
    .frame_count_out(frame_count_out)
  );

  int n_vec = 0, n_err = 0;
  int cyc = 0;
  int pat = 1;
  logic alt_ph = 1'b1;

  // Reference model state
  logic [SW-1:0] sample_q[$];
  logic [32:0]   exp_q[$];
  int m_idx = 0, m_fc = 0, ones = 0, nbits = 0, prev_cyc = 0;
  logic m_ovf = 1'b0, have_prev = 1'b0, prev_mclk = 1'b0;

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  always @(posedge clk_in) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_evt(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: unexpected DUT output (t=%0t)", name, $time);
  endtask

  // Sample value from the count of ones over one decimation window.
  function automatic logic [SW-1:0] ref_sample(input int n_ones);
    int t, top;
    t   = (n_ones >= DECIM) ? DECIM - 1 : n_ones;
    top = t / (1 << (LG - SW));
    return SW'(top - (1 << (SW - 1)));
  endfunction

  // Driver: one new PDM bit per mic clock period, launched on its rising edge.
  initial begin
    logic b;
    mic_data_in = 1'b0;
    forever begin
      @(posedge clk_in);
      #1;
      if (!rst_in) begin
        ones = 0; nbits = 0; sample_q.delete(); exp_q.delete();
        m_idx = 0; m_fc = 0; m_ovf = 1'b0; have_prev = 1'b0; prev_mclk = 1'b0;
      end else begin
        if (mic_clk_out && !prev_mclk) begin
          case (pat)
            1:       b = 1'b1;
            2:       b = 1'b0;
            3:       begin b = alt_ph; alt_ph = ~alt_ph; end
            default: b = 1'($urandom_range(0, 1));
          endcase
          mic_data_in = b;
          ones += int'(b);
          nbits++;
          if (nbits == DECIM) begin
            sample_q.push_back(ref_sample(ones));
            ones = 0;
            nbits = 0;
          end
        end
        prev_mclk = mic_clk_out;
      end
    end
  end

  // Monitor: inputs are stable from negedge through the next posedge.
  always @(negedge clk_in) begin
    logic [SW-1:0] es;
    logic [32:0]   e;
    if (rst_in) begin
      if (sample_valid_out) begin
        if (sample_q.size() == 0) fail_evt("spurious_sample");
        else begin
          es = sample_q.pop_front();
          check("sample", 64'(sample_out), 64'(es));
          if (have_prev) check("sample_period", 64'(cyc - prev_cyc), 64'(SPER));
          prev_cyc  = cyc;
          have_prev = 1'b1;
          check("overflow", 64'(overflow_out), 64'(m_ovf));
          if (m_idx != 0 || enable_in) begin
            if (exp_q.size() >= DEPTH) m_ovf = 1'b1;
            else begin
              exp_q.push_back({(m_idx == FRAME_LEN - 1), 32'(es) << (32 - SW)});
              m_idx = (m_idx + 1) % FRAME_LEN;
            end
          end
        end
      end
      if (m_axis_tvalid) begin
        if (exp_q.size() == 0) fail_evt("extra_beat");
        else if (m_axis_tready) begin
          e = exp_q.pop_front();
          check("beat", 64'({m_axis_tlast, m_axis_tdata}), 64'(e));
          check("frame_count", 64'(frame_count_out), 64'(m_fc % 65536));
          if (e[32]) m_fc++;
        end else begin
          check("stalled_head", 64'({m_axis_tlast, m_axis_tdata}), 64'(exp_q[0]));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_in);
    #2;
  endtask

  task automatic wait_samples(input int n);
    repeat (n * SPER) step();
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) step();
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic mc[4*CLK_DIV];
    int r1, r2, hi;
    rst_in = 1'b0; enable_in = 1'b0; m_axis_tready = 1'b0;
    repeat (3) step();
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_tlast", 64'(m_axis_tlast), 64'd0);
    check("rst_tdata", 64'(m_axis_tdata), 64'd0);
    check("rst_overflow", 64'(overflow_out), 64'd0);
    check("rst_frame_count", 64'(frame_count_out), 64'd0);
    check("rst_mic_clk", 64'(mic_clk_out), 64'd0);
    check("rst_sample", 64'({sample_valid_out, sample_out}), 64'd0);
    rst_in = 1'b1;

    // Mic clock shape
    for (int i = 0; i < 4 * CLK_DIV; i++) begin
      step();
      mc[i] = mic_clk_out;
    end
    r1 = -1; r2 = -1; hi = 0;
    for (int i = 1; i < 4 * CLK_DIV; i++)
      if (mc[i] && !mc[i-1]) begin
        if (r1 < 0) r1 = i;
        else if (r2 < 0) r2 = i;
      end
    for (int i = 0; i < 4 * CLK_DIV; i++) if (r1 >= 0 && i >= r1 && i < r2) hi += int'(mc[i]);
    check("mic_clk_period", 64'(r2 - r1), 64'(CLK_DIV));
    check("mic_clk_high", 64'(hi), 64'(CLK_DIV / 2));

    // Fixed patterns: clamped full scale, zero scale, mid scale
    enable_in = 1'b1; m_axis_tready = 1'b1;
    pat = 1; wait_samples(4);
    pat = 2; wait_samples(3);
    pat = 3; wait_samples(3);

    // Random bits, random backpressure and enable
    pat = 0;
    for (int i = 0; i < 40 * SPER; i++) begin
      m_axis_tready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 63) == 0) enable_in = ~enable_in;
      step();
    end
    m_axis_tready = 1'b1; enable_in = 1'b1;
    drain();

    // Overflow under sustained backpressure
    m_axis_tready = 1'b0;
    wait_samples(DEPTH + 3);
    check("ovf_set", 64'(overflow_out), 64'd1);
    check("ovf_tvalid", 64'(m_axis_tvalid), 64'd1);
    m_axis_tready = 1'b1;
    drain();
    check("ovf_sticky", 64'(overflow_out), 64'd1);

    // Dropping enable lets the current frame finish, then stops
    wait_samples(FRAME_LEN + 1);
    enable_in = 1'b0;
    wait_samples(FRAME_LEN + 2);
    drain();
    check("disabled_idle", 64'(m_axis_tvalid), 64'd0);
    enable_in = 1'b1;
    wait_samples(FRAME_LEN + 1);

    // Reset mid-frame with entries queued
    m_axis_tready = 1'b0;
    wait_samples(2);
    repeat (10) step();
    rst_in = 1'b0;
    step();
    check("mid_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("mid_rst_overflow", 64'(overflow_out), 64'd0);
    check("mid_rst_frame_count", 64'(frame_count_out), 64'd0);
    check("mid_rst_mic_clk", 64'(mic_clk_out), 64'd0);
    rst_in = 1'b1; m_axis_tready = 1'b1; pat = 0;
    wait_samples(2 * FRAME_LEN + 1);
    drain();

    check("final_frame_count", 64'(frame_count_out), 64'(m_fc % 65536));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
